// File: rtl/wb_spm_initiator.sv
// Wishbone classic initiator for the serial-parallel multiplier: writes X and Y, reads the
// 64-bit product back, with a per-access ack timeout. Define WB_SPM_INIT_LAT_EN for lat_o.
module wb_spm_initiator #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_x_i,
  input  logic [31:0] cmd_y_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [63:0] res_prod_o,
  output logic        res_err_o,
  output logic [15:0] lat_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [2:0] {StIdle, StWrX, StWrY, StRdLo, StRdHi, StResp} state_e;

  localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] y_q, y_d;
  logic [31:0] prod_lo_q, prod_lo_d;
  logic [63:0] res_prod_q, res_prod_d;
  logic        res_err_q, res_err_d;
  logic        res_valid_q, res_valid_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [31:0] acc_off;

`ifdef WB_SPM_INIT_LAT_EN
  logic [15:0] lat_cnt_q, lat_cnt_d;
  logic [15:0] lat_q, lat_d;
  logic [15:0] lat_inc;
`endif

  always_comb begin
    case (state_q)
      StWrY:   acc_off = 32'd4;
      StRdLo:  acc_off = 32'd8;
      StRdHi:  acc_off = 32'd12;
      default: acc_off = 32'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    y_d         = y_q;
    prod_lo_d   = prod_lo_q;
    res_prod_d  = res_prod_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    cmd_ready_d = cmd_ready_q;
    // Counts only cycles spent waiting on an outstanding strobe.
    to_cnt_d    = (stb_q && !wbm_ack_i) ? to_cnt_q + 16'd1 : 16'd0;

    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d     = StWrX;
          cmd_ready_d = 1'b0;
          y_d         = cmd_y_i;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = 1'b1;
          sel_d       = 4'hF;
          adr_d       = BASE_ADR;
          dat_d       = cmd_x_i;
        end
      end

      StWrX, StWrY, StRdLo, StRdHi: begin
        if (!stb_q) begin
          // Idle gap after the previous ack has elapsed; launch this state's access.
          cyc_d = 1'b1;
          stb_d = 1'b1;
          sel_d = 4'hF;
          we_d  = (state_q == StWrX) || (state_q == StWrY);
          adr_d = BASE_ADR + acc_off;
          dat_d = (state_q == StWrY) ? y_q : 32'd0;
        end else if (wbm_ack_i) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          sel_d = 4'h0;
          case (state_q)
            StWrX:  state_d = StWrY;
            StWrY:  state_d = StRdLo;
            StRdLo: begin
              prod_lo_d = wbm_dat_i;
              state_d   = StRdHi;
            end
            default: begin
              res_prod_d  = {wbm_dat_i, prod_lo_q};
              res_err_d   = 1'b0;
              res_valid_d = 1'b1;
              state_d     = StResp;
            end
          endcase
        end else if (to_cnt_q == ToLast) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = 4'h0;
          to_cnt_d    = 16'd0;
          res_prod_d  = 64'd0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = StResp;
        end
      end

      StResp: begin
        if (res_ready_i) begin
          state_d     = StIdle;
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

`ifdef WB_SPM_INIT_LAT_EN
  always_comb begin
    lat_inc   = (lat_cnt_q == 16'hFFFF) ? lat_cnt_q : lat_cnt_q + 16'd1;
    lat_cnt_d = lat_cnt_q;
    lat_d     = lat_q;
    if (state_q == StIdle) begin
      lat_cnt_d = 16'd0;
    end else if (state_q != StResp) begin
      lat_cnt_d = lat_inc;
      if (state_d == StResp) lat_d = lat_inc;
    end
  end
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'd0;
      dat_q       <= 32'd0;
      y_q         <= 32'd0;
      prod_lo_q   <= 32'd0;
      res_prod_q  <= 64'd0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      to_cnt_q    <= 16'd0;
`ifdef WB_SPM_INIT_LAT_EN
      lat_cnt_q   <= 16'd0;
      lat_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      y_q         <= y_d;
      prod_lo_q   <= prod_lo_d;
      res_prod_q  <= res_prod_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      cmd_ready_q <= cmd_ready_d;
      to_cnt_q    <= to_cnt_d;
`ifdef WB_SPM_INIT_LAT_EN
      lat_cnt_q   <= lat_cnt_d;
      lat_q       <= lat_d;
`endif
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign res_valid_o = res_valid_q;
  assign res_prod_o  = res_prod_q;
  assign res_err_o   = res_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

`ifdef WB_SPM_INIT_LAT_EN
  assign lat_o = lat_q;
`else
  assign lat_o = 16'd0;
`endif

endmodule

// File: tb/tb_wb_spm_initiator.sv
// Directed bench for wb_spm_initiator: a behavioural multiplier responder with programmable ack
// delay, bus-protocol monitors, and a scoreboard queue of expected results.
module tb_wb_spm_initiator;

  localparam logic [31:0] Base = 32'h3000_0000;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_x, cmd_y;
  logic        res_valid, res_ready, res_err;
  logic [63:0] res_prod;
  logic [15:0] lat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack, ack_m, stray_ack;

  wb_spm_initiator #(.BASE_ADR(Base), .TIMEOUT(255)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_x_i(cmd_x), .cmd_y_i(cmd_y),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_prod_o(res_prod),
    .res_err_o(res_err), .lat_o(lat),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel), .wbm_adr_o(adr),
    .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ack = ack_m | stray_ack;

  // Responder: stores X/Y, returns their product; acks after dly idle strobe cycles.
  int          dly, rdlo_dly, wcnt, cur_dly;
  bit          never_rdlo;
  logic [31:0] mx, my;
  logic [63:0] p;
  logic        is_rdlo;
  logic [32:0] acc_log[$];

  assign p       = {32'd0, mx} * {32'd0, my};
  assign is_rdlo = !we && (adr == Base + 32'd8);
  assign cur_dly = is_rdlo ? rdlo_dly : dly;

  always @(posedge clk) begin
    if (rst) begin
      ack_m <= 1'b0;
      wcnt  <= 0;
    end else if (ack_m) begin
      ack_m <= 1'b0;
      wcnt  <= 0;
    end else if (cyc && stb) begin
      if (!(never_rdlo && is_rdlo) && wcnt >= cur_dly) begin
        ack_m <= 1'b1;
        acc_log.push_back({we, adr});
        if (we && adr == Base) mx <= dat_o;
        if (we && adr == Base + 32'd4) my <= dat_o;
        dat_i <= (adr == Base + 32'd8) ? p[31:0] : p[63:32];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // Protocol monitors: idle gap after ack, stable strobe phase, byte selects, strobe run length.
  int          gap_viol, stab_viol, sel_viol, run, last_run;
  logic        ack_prev, hold_prev;
  logic [32:0] hold_val;

  always @(posedge clk) begin
    if (rst) begin
      ack_prev  <= 1'b0;
      hold_prev <= 1'b0;
      run       <= 0;
    end else begin
      if (ack_prev && stb) gap_viol <= gap_viol + 1;
      if (hold_prev && stb && ({we, adr} !== hold_val)) stab_viol <= stab_viol + 1;
      if (stb && sel !== 4'hF) sel_viol <= sel_viol + 1;
      ack_prev  <= stb && ack;
      hold_prev <= stb && !ack;
      hold_val  <= {we, adr};
      if (stb) run <= run + 1;
      else if (run != 0) begin
        last_run <= run;
        run      <= 0;
      end
    end
  end

  typedef struct packed {logic err; logic [63:0] prod;} exp_t;
  exp_t sb[$];
  int   checks, errors, last_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] x, input logic [31:0] y, input logic err);
    exp_t e;
    int   k;
    e.err  = err;
    e.prod = err ? 64'd0 : {32'd0, x} * {32'd0, y};
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_x     = x;
    cmd_y     = y;
    k         = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_accept", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    int n;
    n = 0;
    while (!res_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    last_lat = n;
    chk("res_wait", 64'(res_valid), 64'd1);
  endtask

  task automatic consume();
    exp_t e;
    chk("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("res_prod", res_prod, e.prod);
      chk("res_err", 64'(res_err), 64'(e.err));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_drop", 64'(res_valid), 64'd0);
    chk("ready_back", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int          k, instab, stray_valid;
    logic [63:0] held;
    checks = 0; errors = 0;
    gap_viol = 0; stab_viol = 0; sel_viol = 0; last_run = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; res_ready = 1'b0; stray_ack = 1'b0;
    dly = 1; rdlo_dly = 65; never_rdlo = 1'b0; mx = '0; my = '0; dat_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_outputs", {res_valid, res_err, cyc, stb, we, sel, lat}, 64'd0);
    chk("rst_prod_adr", {res_prod[31:0] | res_prod[63:32], adr | dat_o}, 64'd0);

    // Ack while strobe is low must be ignored.
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack", {cmd_ready, res_valid, stb}, 64'b100);

    // Basic job with a slow product read.
    acc_log.delete();
    start_job(32'd7, 32'd6, 1'b0);
    wait_valid(400);
    consume();
    chk("log_len", 64'(acc_log.size()), 64'd4);
    if (acc_log.size() == 4) begin
      chk("acc0", 64'(acc_log[0]), 64'({1'b1, Base}));
      chk("acc1", 64'(acc_log[1]), 64'({1'b1, Base + 32'd4}));
      chk("acc2", 64'(acc_log[2]), 64'({1'b0, Base + 32'd8}));
      chk("acc3", 64'(acc_log[3]), 64'({1'b0, Base + 32'd12}));
    end

    // Zero ack delay: 4 accesses of 3 edges each, less the final gap.
    dly = 0; rdlo_dly = 0;
    start_job(32'h0001_0000, 32'h0001_0000, 1'b0);
    wait_valid(100);
    chk("zero_lat", 64'(last_lat), 64'd11);
    consume();
    chk("gap_viol", 64'(gap_viol), 64'd0);
    chk("stab_viol", 64'(stab_viol), 64'd0);
    chk("sel_viol", 64'(sel_viol), 64'd0);

    // Backpressure with an ignored command pulse.
    dly = 1; rdlo_dly = 3;
    acc_log.delete();
    start_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_valid(200);
    held   = res_prod;
    instab = 0;
    for (int i = 0; i < 20; i++) begin
      cmd_valid = (i == 5);
      cmd_x     = 32'd9;
      cmd_y     = 32'd9;
      @(negedge clk);
      if (!res_valid || res_prod !== held || cmd_ready) instab++;
    end
    cmd_valid = 1'b0;
    chk("bp_stable", 64'(instab), 64'd0);
    consume();
    repeat (30) @(negedge clk);
    chk("bp_no_new_job", {32'(acc_log.size()), 31'd0, stb}, {32'd4, 32'd0});

    // Timeout on the product read.
    never_rdlo = 1'b1;
    start_job(32'd2, 32'd3, 1'b1);
    wait_valid(600);
    chk("to_bus_idle", {cyc, stb}, 64'd0);
    consume();
    chk("to_stb_run", 64'(last_run), 64'd255);
    never_rdlo = 1'b0;

    // Reset during the Y write discards the job.
    dly = 1; rdlo_dly = 65;
    start_job(32'd100, 32'd200, 1'b0);
    k = 0;
    while (!(stb && adr == Base + 32'd4) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_wry", {stb, adr}, {31'd0, 1'b1, Base + 32'd4});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_bus", {cyc, stb, cmd_ready, res_valid}, 64'b0010);
    sb.delete();
    stray_valid = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid || stb) stray_valid++;
    end
    chk("midrst_quiet", 64'(stray_valid), 64'd0);
    start_job(32'd3, 32'd5, 1'b0);
    wait_valid(400);
    chk("midrst_prod", res_prod, 64'd15);
    consume();

    // Two-cycle ack delay: each access spans 2+2 strobe cycles plus a gap.
    dly = 2; rdlo_dly = 2;
    start_job(32'd11, 32'd13, 1'b0);
    wait_valid(100);
    chk("lat_measured", 64'(last_lat), 64'd19);
`ifdef WB_SPM_INIT_LAT_EN
    chk("lat_o", 64'(lat), 64'(last_lat));
`else
    chk("lat_o_off", 64'(lat), 64'd0);
`endif
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
